// File: rtl/stream_arb2.sv
// Two-requester round-robin arbiter in front of a shared in-order unit.
// A tag FIFO records which requester issued each request so results return to their owner.
module stream_arb2 #(
  parameter int unsigned N     = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       nrst,
  input  logic [N-1:0]               in0,
  input  logic                       in0_valid,
  output logic                       in0_ready,
  input  logic [N-1:0]               in1,
  input  logic                       in1_valid,
  output logic                       in1_ready,
  output logic [N-1:0]               req,
  output logic                       req_valid,
  input  logic                       req_ready,
  input  logic [N-1:0]               res,
  input  logic                       res_valid,
  output logic                       res_ready,
  output logic [N-1:0]               out0,
  output logic [N-1:0]               out1,
  output logic                       out0_valid,
  output logic                       out1_valid,
  input  logic                       out0_ready,
  input  logic                       out1_ready,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       err
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic             last_q, last_d;
  logic [CW-1:0]    count_q, count_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic             err_q, err_d;
  logic [DEPTH-1:0] tags_q, tags_d;

  logic gnt_idx;
  logic not_full;
  logic nonempty;
  logic head_tag;
  logic req_fire;
  logic res_fire;

  // Request side: round-robin grant, gated off while full or in reset.
  always_comb begin
    not_full = (count_q < CW'(DEPTH));
    gnt_idx  = 1'b0;
    if (in0_valid && in1_valid) begin
      gnt_idx = ~last_q;
    end else begin
      gnt_idx = in1_valid;
    end
    req_valid = nrst & not_full & (in0_valid | in1_valid);
    req       = '0;
    if (req_valid) begin
      req = gnt_idx ? in1 : in0;
    end
    in0_ready = req_valid & ~gnt_idx & req_ready;
    in1_ready = req_valid &  gnt_idx & req_ready;
    req_fire  = req_valid & req_ready;
  end

  // Result side: steer res to the owner recorded at the FIFO head.
  always_comb begin
    nonempty   = (count_q != '0);
    head_tag   = tags_q[rd_ptr_q];
    res_ready  = nrst & nonempty & (head_tag ? out1_ready : out0_ready);
    out0_valid = nrst & nonempty & ~head_tag & res_valid;
    out1_valid = nrst & nonempty &  head_tag & res_valid;
    out0       = res;
    out1       = res;
    res_fire   = res_valid & res_ready;
  end

  // Next-state for arbitration history, tag FIFO, occupancy and error flag.
  always_comb begin
    last_d   = last_q;
    tags_d   = tags_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    err_d    = err_q;
    if (req_fire) begin
      last_d           = gnt_idx;
      tags_d[wr_ptr_q] = gnt_idx;
      wr_ptr_d         = wr_ptr_q + PW'(1);
    end
    if (res_fire) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    case ({req_fire, res_fire})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    // A result with nothing outstanding is a protocol violation by the unit.
    if (res_valid && !nonempty) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      last_q   <= 1'b1;
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      err_q    <= 1'b0;
      tags_q   <= '0;
    end else begin
      last_q   <= last_d;
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      err_q    <= err_d;
      tags_q   <= tags_d;
    end
  end

  assign count = count_q;
  assign err   = err_q;

endmodule

// File: tb/tb_stream_arb2.sv
// Bench for stream_arb2: directed scenarios plus randomized traffic against a queue-based model.
module tb_stream_arb2;

  localparam int unsigned N     = 8;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          nrst;
  logic [N-1:0]  in0, in1, req, res, out0, out1;
  logic          in0_valid, in0_ready, in1_valid, in1_ready;
  logic          req_valid, req_ready, res_valid, res_ready;
  logic          out0_valid, out1_valid, out0_ready, out1_ready;
  logic [CW-1:0] count;
  logic          err;

  int checks   = 0;
  int failures = 0;

  int unsigned  m_tags[$];
  logic [N-1:0] unit_q[$];
  logic [N-1:0] exp_q0[$];
  logic [N-1:0] exp_q1[$];
  bit           m_last;
  bit           m_err;

  stream_arb2 #(.N(N), .DEPTH(DEPTH)) dut (
    .clk(clk), .nrst(nrst),
    .in0(in0), .in0_valid(in0_valid), .in0_ready(in0_ready),
    .in1(in1), .in1_valid(in1_valid), .in1_ready(in1_ready),
    .req(req), .req_valid(req_valid), .req_ready(req_ready),
    .res(res), .res_valid(res_valid), .res_ready(res_ready),
    .out0(out0), .out1(out1), .out0_valid(out0_valid), .out1_valid(out1_valid),
    .out0_ready(out0_ready), .out1_ready(out1_ready),
    .count(count), .err(err)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  task automatic idle();
    in0 = '0; in1 = '0; in0_valid = 1'b0; in1_valid = 1'b0;
    req_ready = 1'b0; res = '0; res_valid = 1'b0;
    out0_ready = 1'b0; out1_ready = 1'b0;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    nrst = 1'b0;
    #2;
    nrst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    nrst = 1'b0;
    idle();
    in0_valid = 1'b1; in1_valid = 1'b1; req_ready = 1'b1;
    res_valid = 1'b1; out0_ready = 1'b1; out1_ready = 1'b1;
    #2;
    checks++; if (req_valid !== 1'b0) begin failures++; $display("FAIL reset_req_valid got=%0b exp=0", req_valid); end
    checks++; if ({in0_ready, in1_ready} !== 2'b00) begin failures++; $display("FAIL reset_in_ready got=%b exp=00", {in0_ready, in1_ready}); end
    checks++; if ({res_ready, out0_valid, out1_valid} !== 3'b000) begin failures++; $display("FAIL reset_res_side got=%b exp=000", {res_ready, out0_valid, out1_valid}); end
    checks++; if (count !== CW'(0)) begin failures++; $display("FAIL reset_count got=%0d exp=0", count); end
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL reset_err got=%0b exp=0", err); end
    idle();
    @(negedge clk); nrst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_single();
    idle();
    in0 = 8'd5; in0_valid = 1'b1; req_ready = 1'b1;
    @(negedge clk);
    checks++; if (req_valid !== 1'b1 || req !== 8'd5) begin failures++; $display("FAIL single_req got=%0b/%0d exp=1/5", req_valid, req); end
    checks++; if ({in0_ready, in1_ready} !== 2'b10) begin failures++; $display("FAIL single_ready got=%b exp=10", {in0_ready, in1_ready}); end
    @(posedge clk); #1;
    in0_valid = 1'b0; res = 8'd6; res_valid = 1'b1; out0_ready = 1'b1; out1_ready = 1'b1;
    @(negedge clk);
    checks++; if (count !== CW'(1)) begin failures++; $display("FAIL single_count1 got=%0d exp=1", count); end
    checks++; if (out0_valid !== 1'b1 || out0 !== 8'd6 || out1_valid !== 1'b0) begin failures++; $display("FAIL single_out got=%0b/%0d/%0b exp=1/6/0", out0_valid, out0, out1_valid); end
    checks++; if (res_ready !== 1'b1) begin failures++; $display("FAIL single_res_ready got=%0b exp=1", res_ready); end
    @(posedge clk); #1;
    res_valid = 1'b0;
    @(negedge clk);
    checks++; if (count !== CW'(0) || err !== 1'b0) begin failures++; $display("FAIL single_count0 got=%0d/%0b exp=0/0", count, err); end
    @(posedge clk); #1;
  endtask

  task automatic test_round_robin();
    logic [N-1:0] exp_seq [4];
    exp_seq[0] = 8'd10; exp_seq[1] = 8'd20; exp_seq[2] = 8'd10; exp_seq[3] = 8'd20;
    pulse_reset();
    idle();
    in0 = 8'd10; in1 = 8'd20; in0_valid = 1'b1; in1_valid = 1'b1; req_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++; if (req_valid !== 1'b1 || req !== exp_seq[i]) begin failures++; $display("FAIL rr_req[%0d] got=%0b/%0d exp=1/%0d", i, req_valid, req, exp_seq[i]); end
      checks++; if (in1_ready !== 1'(i % 2) || in0_ready !== 1'((i + 1) % 2)) begin failures++; $display("FAIL rr_grant[%0d] got=%b", i, {in1_ready, in0_ready}); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_full();
    @(negedge clk);
    checks++; if (req_valid !== 1'b0 || count !== CW'(DEPTH)) begin failures++; $display("FAIL full_hold got=%0b/%0d exp=0/%0d", req_valid, count, DEPTH); end
    checks++; if ({in0_ready, in1_ready} !== 2'b00) begin failures++; $display("FAIL full_in_ready got=%b exp=00", {in0_ready, in1_ready}); end
    @(posedge clk); #1;
    res = 8'd11; res_valid = 1'b1; out0_ready = 1'b1;
    @(negedge clk);
    checks++; if (res_ready !== 1'b1 || out0_valid !== 1'b1) begin failures++; $display("FAIL full_pop got=%0b/%0b exp=1/1", res_ready, out0_valid); end
    checks++; if (req_valid !== 1'b0) begin failures++; $display("FAIL full_no_bypass got=%0b exp=0", req_valid); end
    @(posedge clk); #1;
    res_valid = 1'b0; req_ready = 1'b0;
    @(negedge clk);
    checks++; if (count !== CW'(3) || req_valid !== 1'b1) begin failures++; $display("FAIL full_reopen got=%0d/%0b exp=3/1", count, req_valid); end
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    in0_valid = 1'b0; in1_valid = 1'b0;
    res = 8'd21; res_valid = 1'b1; out0_ready = 1'b1; out1_ready = 1'b0;
    @(negedge clk);
    checks++; if (res_ready !== 1'b0) begin failures++; $display("FAIL bp_res_ready got=%0b exp=0", res_ready); end
    checks++; if (out0_valid !== 1'b0 || out1_valid !== 1'b1) begin failures++; $display("FAIL bp_valids got=%0b/%0b exp=0/1", out0_valid, out1_valid); end
    @(posedge clk); #1;
    @(negedge clk);
    checks++; if (count !== CW'(3)) begin failures++; $display("FAIL bp_hold_count got=%0d exp=3", count); end
    @(posedge clk); #1;
    out1_ready = 1'b1;
    @(negedge clk);
    checks++; if (res_ready !== 1'b1 || out1 !== 8'd21) begin failures++; $display("FAIL bp_release got=%0b/%0d exp=1/21", res_ready, out1); end
    @(posedge clk); #1;
    res_valid = 1'b0;
  endtask

  task automatic test_reset_midflight();
    in0 = 8'd10; in1 = 8'd20; in0_valid = 1'b1; in1_valid = 1'b1; req_ready = 1'b1;
    res_valid = 1'b1; out0_ready = 1'b1; out1_ready = 1'b1;
    @(negedge clk);
    checks++; if (count !== CW'(2)) begin failures++; $display("FAIL mid_pre_count got=%0d exp=2", count); end
    #1; nrst = 1'b0; #1;
    checks++; if (count !== CW'(0)) begin failures++; $display("FAIL mid_count got=%0d exp=0", count); end
    checks++; if ({req_valid, in0_ready, in1_ready, res_ready, out0_valid, out1_valid} !== 6'b0) begin failures++; $display("FAIL mid_outputs got=%b exp=000000", {req_valid, in0_ready, in1_ready, res_ready, out0_valid, out1_valid}); end
    res_valid = 1'b0;
    @(posedge clk); #2;
    nrst = 1'b1; #1;
    checks++; if (req_valid !== 1'b1 || in0_ready !== 1'b1 || req !== 8'd10) begin failures++; $display("FAIL mid_first_grant got=%0b/%0b/%0d exp=1/1/10", req_valid, in0_ready, req); end
    @(posedge clk); #1;
    @(negedge clk);
    checks++; if (in1_ready !== 1'b1 || req !== 8'd20) begin failures++; $display("FAIL mid_second_grant got=%0b/%0d exp=1/20", in1_ready, req); end
    @(posedge clk); #1;
    idle();
  endtask

  task automatic test_err();
    pulse_reset();
    idle();
    res = 8'd99; res_valid = 1'b1; out0_ready = 1'b1; out1_ready = 1'b1;
    @(negedge clk);
    checks++; if ({res_ready, out0_valid, out1_valid} !== 3'b000 || err !== 1'b0) begin failures++; $display("FAIL err_pre got=%b/%0b exp=000/0", {res_ready, out0_valid, out1_valid}, err); end
    @(posedge clk); #1;
    res_valid = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    @(negedge clk);
    checks++; if (err !== 1'b1) begin failures++; $display("FAIL err_sticky got=%0b exp=1", err); end
    nrst = 1'b0; #1;
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL err_clear got=%0b exp=0", err); end
    nrst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    bit           full, busy, e_rv, e_g, e_head, e_rr, e_o0v, e_o1v, push, pop;
    logic [N-1:0] e_req, r;
    pulse_reset();
    idle();
    m_tags.delete(); unit_q.delete(); exp_q0.delete(); exp_q1.delete();
    m_last = 1'b1; m_err = 1'b0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      in0 = N'($urandom); in1 = N'($urandom);
      in0_valid = 1'($urandom_range(0, 1)); in1_valid = 1'($urandom_range(0, 1));
      req_ready = ($urandom_range(0, 3) != 0);
      res_valid = (unit_q.size() > 0) && ($urandom_range(0, 2) != 0);
      res = (unit_q.size() > 0) ? unit_q[0] : N'($urandom);
      out0_ready = ($urandom_range(0, 3) != 0); out1_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      full   = (m_tags.size() == DEPTH);
      busy   = (m_tags.size() > 0);
      e_rv   = !full && (in0_valid || in1_valid);
      e_g    = (in0_valid && in1_valid) ? !m_last : bit'(in1_valid);
      e_req  = e_rv ? (e_g ? in1 : in0) : '0;
      e_head = busy ? bit'(m_tags[0]) : 1'b0;
      e_rr   = busy && (e_head ? out1_ready : out0_ready);
      e_o0v  = busy && !e_head && res_valid;
      e_o1v  = busy &&  e_head && res_valid;
      checks++; if (req_valid !== e_rv || req !== e_req) begin failures++; $display("FAIL rnd_req c%0d got=%0b/%0d exp=%0b/%0d", cyc, req_valid, req, e_rv, e_req); end
      checks++; if (in0_ready !== (e_rv && !e_g && req_ready) || in1_ready !== (e_rv && e_g && req_ready)) begin failures++; $display("FAIL rnd_in_ready c%0d got=%b exp_g=%0b", cyc, {in1_ready, in0_ready}, e_g); end
      checks++; if (res_ready !== e_rr || out0_valid !== e_o0v || out1_valid !== e_o1v) begin failures++; $display("FAIL rnd_res c%0d got=%b exp=%b", cyc, {res_ready, out0_valid, out1_valid}, {e_rr, e_o0v, e_o1v}); end
      checks++; if (count !== CW'(m_tags.size()) || err !== m_err) begin failures++; $display("FAIL rnd_state c%0d got=%0d/%0b exp=%0d/%0b", cyc, count, err, m_tags.size(), m_err); end
      push = e_rv && req_ready;
      pop  = res_valid && e_rr;
      if (res_valid && !busy) m_err = 1'b1;
      if (pop) begin
        if (!e_head) begin
          checks++; if (exp_q0.size() == 0 || out0 !== exp_q0[0]) begin failures++; $display("FAIL rnd_out0 c%0d got=%0d", cyc, out0); end
          if (exp_q0.size() > 0) void'(exp_q0.pop_front());
        end else begin
          checks++; if (exp_q1.size() == 0 || out1 !== exp_q1[0]) begin failures++; $display("FAIL rnd_out1 c%0d got=%0d", cyc, out1); end
          if (exp_q1.size() > 0) void'(exp_q1.pop_front());
        end
        void'(m_tags.pop_front());
        void'(unit_q.pop_front());
      end
      if (push) begin
        r = e_req + N'(1);
        m_tags.push_back(int'(e_g));
        m_last = e_g;
        unit_q.push_back(r);
        if (e_g) exp_q1.push_back(r); else exp_q0.push_back(r);
      end
      @(posedge clk); #1;
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_full();
    test_backpressure();
    test_reset_midflight();
    test_err();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/stream_arb2.md
STREAM_ARB2 -- requirements
Module: stream_arb2

Interface
REQ-001 SHALL have parameter N, default 8: stream data width in bits.
REQ-002 SHALL have parameter DEPTH, default 4: maximum outstanding requests, power of two, at least 2.
REQ-003 SHALL have port clk, input, 1: the single clock; all state updates on posedge clk.
REQ-004 SHALL have port nrst, input, 1: asynchronous active-low reset.
REQ-005 SHALL have ports in0 (input, N), in0_valid (input, 1), in0_ready (output, 1): requester 0 stream.
REQ-006 SHALL have ports in1 (input, N), in1_valid (input, 1), in1_ready (output, 1): requester 1 stream.
REQ-007 SHALL have ports req (output, N), req_valid (output, 1), req_ready (input, 1): stream into the shared in-order unit, e.g. map_add1.
REQ-008 SHALL have ports res (input, N), res_valid (input, 1), res_ready (output, 1): result stream from the shared unit.
REQ-009 SHALL have ports out0, out1 (output, N each), out0_valid, out1_valid (output, 1 each), out0_ready, out1_ready (input, 1 each): per-requester result streams.
REQ-010 SHALL have port count, output, log2(DEPTH)+1: number of outstanding requests.
REQ-011 SHALL have port err, output, 1: sticky protocol-error flag.

Function
REQ-012 SHALL treat a stream transfer as occurring on a posedge where valid and ready are both 1.
REQ-013 SHALL compute grant combinationally and assert req_valid only when count < DEPTH and in0_valid or in1_valid is 1.
REQ-014 SHALL grant the only valid requester when exactly one is valid.
REQ-015 SHALL grant the requester not named by register last when both are valid (round-robin).
REQ-016 SHALL drive req with the granted input's data, and req with 0 when there is no grant.
REQ-017 SHALL drive the granted input's ready equal to req_ready, and hold the ungranted input's ready at 0.
REQ-018 SHALL, on each req transfer, update last to the granted index and push that index into a DEPTH-entry tag FIFO.
REQ-019 SHALL hold the grant stable while req_valid=1 and req_ready=0, provided inputs are held per protocol; last changes only on transfer.
REQ-020 SHALL, when count > 0, route res to the output named by the FIFO head: outK=res, outK_valid=res_valid, res_ready=outK_ready.
REQ-021 SHALL hold the non-selected output's valid at 0 and drive both out0 and out1 data with res.
REQ-022 SHALL pop the FIFO head on each res transfer.
REQ-023 SHALL, when count = 0, drive res_ready=0 and both outK_valid=0, and set err=1 if res_valid=1.
REQ-024 SHALL update count by +1 on push only, -1 on pop only, and leave it unchanged on simultaneous push and pop.
REQ-025 SHALL not grant when count = DEPTH, even if a pop occurs in the same cycle (no full bypass).
REQ-026 SHALL allow a push into an empty FIFO and a res transfer in the same cycle only when count > 0 beforehand; results never bypass the FIFO.
REQ-027 SHALL wrap FIFO read and write pointers modulo DEPTH.
REQ-028 SHALL keep err at 1 until reset once it is set.

Reset
REQ-029 SHALL, while nrst=0, asynchronously clear count, the FIFO pointers and err to 0, and set last to 1 so that requester 0 wins the first contention.
REQ-030 SHALL, during reset, force every ready and valid output to 0 combinationally; outstanding tags are discarded.

Verification
REQ-031 SHALL cover: in0_valid=1 with in0=5, in1_valid=0, req_ready=1, and the unit returning 6 -> req=5 with tag 0, out0=6 with out0_valid=1, out1_valid=0, count 1 then 0.
REQ-032 SHALL cover: both inputs valid for 4 cycles with in0=10 and in1=20, req_ready=1 -> grant order 0,1,0,1 and req sequence 10,20,10,20.
REQ-033 SHALL cover: DEPTH=4, res_valid held at 0, both inputs valid -> exactly 4 transfers, then req_valid=0 and count=4; after one res transfer, count=3 and req_valid returns to 1 on the next cycle.
REQ-034 SHALL cover: out1_ready=0 while the head tag is 1 -> res_ready=0, the FIFO holds, and out0 receives nothing even if out0_ready=1.
REQ-035 SHALL cover: res_valid=1 while count=0 -> err=1 and held until nrst pulses low.
REQ-036 SHALL cover: nrst driven low with count=2 -> count=0 immediately, all valid and ready outputs 0, and the first grant after release goes to in0 under contention.
